// File: rtl/inst_fetch.sv
// inst_fetch: single-issue instruction fetch stage with one-cycle-latency
// instruction memory, a one-entry hold buffer for decode back-pressure and
// an execute-stage redirect.
//
// Optional feature: define STATIC_BTFN_EN to enable static backward-taken /
// forward-not-taken prediction (JAL always taken, backward BRANCH taken).
//
// Ports:
//   clk          sole clock, rising edge
//   rst          asynchronous active-low reset
//   imem_addr    instruction memory byte address (word aligned)
//   imem_en      fetch request; data returns on imem_dout one cycle later
//   imem_dout    instruction for the previous-cycle request
//   stall        decode not accepting this cycle
//   redirect     execute-stage PC override
//   redirect_pc  override target
//   inst_out     instruction to decode
//   pc_out       byte address of inst_out
//   inst_valid   inst_out/pc_out valid; consumed when inst_valid & ~stall
//   pred_taken   inst_out was predicted taken
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  output logic        imem_en,
  input  logic [31:0] imem_dout,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out,
  output logic        inst_valid,
  output logic        pred_taken
);

  typedef enum logic [1:0] {
    EMPTY,
    FETCH,
    HOLD
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q;
  logic        req_q;
  logic [31:0] req_pc_q;
  logic [31:0] hold_q;
  logic [31:0] hold_pc_q;

  logic [31:0] cur_inst;
  logic [31:0] cur_pc;
  logic        cur_valid;
  logic        consume;
  logic        issue;
  logic        capture;
  logic [31:0] issue_addr;
  logic        pred_hit;
  logic [31:0] pred_target;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Any issue (sequential, predicted or redirect) leaves a
  // request outstanding; a stalled FETCH parks its response in the hold regs.
  always_comb begin
    state_d = state_q;
    if (issue) begin
      state_d = FETCH;
    end else if (state_q == FETCH) begin
      state_d = HOLD;
    end
  end

  // Output / control logic
  always_comb begin
    cur_inst  = '0;
    cur_pc    = '0;
    cur_valid = 1'b0;
    unique case (state_q)
      FETCH: begin
        cur_inst  = imem_dout;
        cur_pc    = req_pc_q;
        cur_valid = req_q;
      end
      HOLD: begin
        cur_inst  = hold_q;
        cur_pc    = hold_pc_q;
        cur_valid = 1'b1;
      end
      default: ;
    endcase

    inst_out   = cur_inst;
    pc_out     = cur_pc;
    // A redirect squashes whatever is presented this cycle.
    inst_valid = cur_valid & ~redirect;
    consume    = inst_valid & ~stall;
    // rst gating keeps the memory quiet while reset is held.
    issue      = rst & (~stall | redirect);
    capture    = rst & (state_q == FETCH) & ~issue;

    if (redirect) begin
      issue_addr = {redirect_pc[31:2], 2'b00};
    end else if (pred_hit) begin
      issue_addr = pred_target;
    end else begin
      issue_addr = pc_q;
    end

    imem_en    = issue;
    imem_addr  = issue_addr;
    pred_taken = pred_hit;
  end

`ifdef STATIC_BTFN_EN
  logic [6:0]  opcode;
  logic        is_jal;
  logic        is_back_br;
  logic [31:0] imm_b;
  logic [31:0] imm_j;

  always_comb begin
    opcode     = cur_inst[6:0];
    is_jal     = (opcode == 7'b1101111);
    is_back_br = (opcode == 7'b1100011) & cur_inst[31];
    imm_b      = {{20{cur_inst[31]}}, cur_inst[7], cur_inst[30:25],
                  cur_inst[11:8], 1'b0};
    imm_j      = {{12{cur_inst[31]}}, cur_inst[19:12], cur_inst[20],
                  cur_inst[30:21], 1'b0};
    // Predict only when the instruction is actually handed to decode, so a
    // held instruction is steered exactly once.
    pred_hit    = consume & (is_jal | is_back_br);
    pred_target = cur_pc + (is_jal ? imm_j : imm_b);
  end
`else
  always_comb begin
    pred_hit    = 1'b0;
    pred_target = '0;
  end
`endif

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q      <= RESET_PC;
      req_q     <= 1'b0;
      req_pc_q  <= '0;
      hold_q    <= '0;
      hold_pc_q <= '0;
    end else begin
      req_q <= issue;
      if (issue) begin
        pc_q     <= issue_addr + 32'd4;
        req_pc_q <= issue_addr;
      end
      if (capture) begin
        hold_q    <= imem_dout;
        hold_pc_q <= req_pc_q;
      end
    end
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h4000_0000, first fetch byte address after reset.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port imem_addr  output  32  instruction memory byte address.
REQ-005 SHALL have port imem_en  output  1  fetch request; memory returns data exactly 1 cycle later.
REQ-006 SHALL have port imem_dout  input  32  instruction returned for previous-cycle request.
REQ-007 SHALL have port stall  input  1  decode not accepting this cycle.
REQ-008 SHALL have port redirect  input  1  execute-stage PC override (jump/mispredict).
REQ-009 SHALL have port redirect_pc  input  32  override target.
REQ-010 SHALL have port inst_out  output  32  instruction to decode/immediate generation.
REQ-011 SHALL have port pc_out  output  32  byte address of inst_out.
REQ-012 SHALL have port inst_valid  output  1  inst_out/pc_out valid; consumed when inst_valid & ~stall.
REQ-013 SHALL have port pred_taken  output  1  inst_out was predicted taken.

Function
REQ-014 SHALL keep pc_q (next fetch address), req_q/req_pc_q (outstanding request and its address), hold_q/hold_pc_q (held instruction and its address).
REQ-015 SHALL implement FSM EMPTY (nothing outstanding/held), FETCH (req_q=1), HOLD (hold valid); EMPTY is entered from reset.
REQ-016 SHALL issue when ~stall or redirect: imem_en=1, imem_addr=pc_q (or redirect target); pc_q<=issued address+4, mod 2^32 (0xFFFF_FFFC wraps to 0); next state FETCH.
REQ-017 SHALL, when stall & ~redirect, drive imem_en=0 and leave pc_q unchanged.
REQ-018 SHALL drive inst_out=imem_dout, pc_out=req_pc_q, inst_valid=1 in FETCH; inst_out=hold_q, pc_out=hold_pc_q, inst_valid=1 in HOLD; inst_valid=0 in EMPTY.
REQ-019 SHALL, in FETCH with stall & ~redirect, capture imem_dout/req_pc_q into hold regs; next state HOLD.
REQ-020 SHALL, in HOLD with ~stall, consume hold regs and issue per REQ-016 in the same cycle; next state FETCH.
REQ-021 SHALL, in HOLD with stall, keep hold regs unchanged and imem_en=0.
REQ-022 SHALL give redirect priority over stall and prediction: inst_valid=0 that cycle, hold discarded, imem_addr={redirect_pc[31:2],2'b00}, pc_q<=that+4, next state FETCH.
REQ-023 SHALL never present an instruction twice nor drop one absent redirect.

Reset
REQ-024 SHALL, while rst=0, force pc_q=RESET_PC, req_q=0, hold cleared, state EMPTY, inst_valid=0, imem_en=0, pred_taken=0, inst_out=0, pc_out=0.
REQ-025 SHALL discard any outstanding memory response when reset asserts mid-operation; first cycle after deassertion issues RESET_PC.

Configuration
REQ-026 SHALL, with STATIC_BTFN_EN defined, predict in the consume cycle (inst_valid & ~stall & ~redirect): JAL (opcode 1101111) or BRANCH (1100011) with inst[31]=1 -> issue pc_out+J/B immediate (sign-extended, bit0=0) instead of pc_q, pc_q<=target+4, pred_taken=1 with that instruction.
REQ-027 SHALL, without STATIC_BTFN_EN, fetch sequentially only and tie pred_taken to 0.

Verification
REQ-028 SHALL test reset release, no stall -> imem_addr 0x4000_0000, 0x4000_0004, ...; pc_out lags one cycle.
REQ-029 SHALL test stall 3 cycles while FETCH -> HOLD, same inst_out/pc_out held, imem_en=0, no skip/duplicate after release.
REQ-030 SHALL test redirect=1, redirect_pc=0x1000_0002, stall=1 -> imem_addr=0x1000_0000, inst_valid=0, next pc_out=0x1000_0000.
REQ-031 SHALL test pc_q=0xFFFF_FFFC -> next address 0x0000_0000.
REQ-032 SHALL test with STATIC_BTFN_EN: inst 0xFE000EE3 (beq, offset -4) at 0x100 -> imem_addr=0xFC, pred_taken=1; forward beq -> 0x104, pred_taken=0.
REQ-033 SHALL test rst pulsed low mid-FETCH -> outputs zero immediately; restart at RESET_PC.
